// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared UART transmit definitions: frame states and line-level constants.
package uart_tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_frame_ctrl_parity_calc.sv
// Combinational parity generator: XOR reduction of the data word with even/odd select.
module uart_parity_calc
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  function automatic logic reduce_xor(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  // Even parity is the plain XOR; odd parity is its inverse.
  always_comb begin
    par_bit = 1'b0;
    if (par_typ == PAR_ODD) begin
      par_bit = ~reduce_xor(data);
    end else begin
      par_bit = reduce_xor(data);
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, serializer data, optional parity
// and stop bits onto the line, with a watchdog against a stalled serializer.
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  FRAME_ERR
);

  localparam int CNT_W = $clog2(DATA_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_TIMEOUT - 1);

  uart_state_e      state_r;
  logic             par_bit_r;
  logic             par_en_r;
  logic             frame_err_r;
  logic [CNT_W-1:0] wdog_r;
  logic             par_bit_s;
  logic             wdog_exp_s;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit_s)
  );

  // The current DATA cycle is the last one allowed once the count reaches TIMEOUT-1.
  assign wdog_exp_s = (wdog_r >= CNT_LAST);

  // Frame sequencer, parity/enable capture, watchdog and error pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      par_bit_r   <= 1'b0;
      par_en_r    <= 1'b0;
      frame_err_r <= 1'b0;
      wdog_r      <= '0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (DATA_VALID) begin
            state_r   <= START;
            par_bit_r <= par_bit_s;
            par_en_r  <= PAR_EN;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          state_r <= DATA;
          wdog_r  <= '0;
        end
        DATA: begin
          if (wdog_r != CNT_MAX) begin
            wdog_r <= wdog_r + CNT_W'(1);
          end else begin
            wdog_r <= wdog_r;
          end
          // A completion seen on the final allowed cycle still counts as a clean exit.
          if (ser_done) begin
            state_r <= par_en_r ? PARITY : STOP;
          end else if (wdog_exp_s) begin
            state_r     <= STOP;
            frame_err_r <= 1'b1;
          end else begin
            state_r <= DATA;
          end
        end
        PARITY: begin
          state_r <= STOP;
        end
        STOP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Line and serializer control decode from the current state.
  always_comb begin
    TX_OUT = LINE_IDLE;
    busy   = 1'b1;
    ser_en = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      START: begin
        TX_OUT = START_BIT;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
      end
      PARITY: begin
        TX_OUT = par_bit_r;
      end
      STOP: begin
        TX_OUT = STOP_BIT;
      end
      default: begin
        TX_OUT = LINE_IDLE;
        busy   = 1'b0;
      end
    endcase
  end

  assign FRAME_ERR = frame_err_r;

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Frame controller and output stage of the UART transmitter, directly downstream of the serializer. Accepts a byte request, sequences start bit, serializer-driven data bits, optional parity bit and stop bit onto the line, and drives the serializer's `ser_en` and `busy` controls. Parity is computed and captured here. A watchdog recovers if the serializer never reports completion.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; also the width of `P_DATA`.
- `DATA_TIMEOUT`, 16: maximum number of cycles allowed in DATA before the frame is aborted.
- `CLK`  input  1: sole clock, rising edge.
- `RST`  input  1: asynchronous, active-low reset.
- `P_DATA`  input  DATA_WIDTH: byte to transmit, sampled at acceptance; used for parity only.
- `DATA_VALID`  input  1: transmit request.
- `PAR_EN`  input  1: 1 = insert parity bit; sampled at acceptance.
- `PAR_TYP`  input  1: 0 = even, 1 = odd; sampled at acceptance.
- `ser_data`  input  1: current data bit from the serializer.
- `ser_done`  input  1: serializer reports that the last data bit has been presented.
- `ser_en`  output  1: enables the serializer shift.
- `busy`  output  1: frame in progress; blocks the serializer from reloading.
- `TX_OUT`  output  1: serial line, idle high.
- `FRAME_ERR`  output  1: one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- IDLE -> START when `DATA_VALID` = 1.
  - At acceptance, capture `par_bit` = XOR of `P_DATA` when `PAR_TYP` = 0, or its inverse when `PAR_TYP` = 1.
  - At acceptance, capture `PAR_EN` into `par_en_q`.
  - `DATA_VALID` outside IDLE is ignored. No queueing.
- START -> DATA unconditionally after 1 cycle.
- DATA:
  - `ser_en` = 1.
  - Leave on the cycle `ser_done` is sampled 1: go to PARITY if `par_en_q` = 1, else to STOP.
- PARITY -> STOP after 1 cycle.
- STOP -> IDLE after 1 cycle. There is no direct STOP -> START path. At least one IDLE cycle separates frames, so the serializer can load with `busy` = 0.
- Watchdog:
  - A counter clears on DATA entry and increments each DATA cycle.
  - If it reaches `DATA_TIMEOUT` with `ser_done` still 0: go to STOP, skip PARITY, and pulse `FRAME_ERR` for 1 cycle.
  - Counter width is $clog2(DATA_TIMEOUT+1). It saturates and never wraps.
- Output decode (combinational from state):
  - `TX_OUT`: IDLE = 1, START = 0, DATA = `ser_data`, PARITY = `par_bit`, STOP = 1.
  - `busy` = 1 in every state except IDLE.
  - `ser_en` = 1 in DATA only.
- Simultaneous events: if `ser_done` = 1 and the watchdog expires in the same cycle, `ser_done` wins: normal exit, no `FRAME_ERR`.

## Timing
- Reset values: state IDLE, `TX_OUT` = 1, `busy` = 0, `ser_en` = 0, `FRAME_ERR` = 0, `par_bit` = 0, `par_en_q` = 0, watchdog = 0.
- Reset asserted mid-frame forces all of the above immediately, independent of `CLK`.
- Acceptance to line start: `DATA_VALID` sampled at edge N; `TX_OUT` = 0 during cycle N+1.
- DATA length equals the cycle count until `ser_done`. With the 8-bit serializer this is 8 bit-times.
- Frame length with parity enabled: 1 + D + 1 + 1 cycles, where D is the DATA length. Without parity: 1 + D + 1. Add 1 IDLE cycle between back-to-back frames.
- `FRAME_ERR` is registered. It is high in the first STOP cycle of an aborted frame.

## Structure
- Shared UART package holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants `LINE_IDLE` = 1, `START_BIT` = 0, `STOP_BIT` = 1;
  - constants `PAR_EVEN` = 0, `PAR_ODD` = 1.
- One natural sub-module, `uart_parity_calc`: combinational XOR reduction with odd/even select. The FSM, watchdog and output mux stay in this module.

## Test plan
- Reset mid-DATA: assert `RST` low -> `TX_OUT` = 1, `busy` = 0 and `ser_en` = 0 in the same cycle; after release, state is IDLE.
- `P_DATA` = 0xA5, `PAR_EN` = 1, `PAR_TYP` = 0, serializer model with `ser_done` after 8 cycles -> `TX_OUT` sequence 0, 1,0,1,0,0,1,0,1, 0 (even parity), 1; `busy` high for 11 cycles.
- `P_DATA` = 0xA5, `PAR_TYP` = 1 -> parity bit 1. Same byte with `PAR_EN` = 0 -> 10-cycle frame, no parity slot.
- `DATA_VALID` held high continuously -> frames are separated by exactly one cycle with `TX_OUT` = 1 and `busy` = 0. A request during a frame does not restart it.
- `ser_done` never asserted, `DATA_TIMEOUT` = 16 -> after 16 DATA cycles: STOP, `FRAME_ERR` pulses once, then IDLE. `ser_done` and timeout coincident -> no `FRAME_ERR`.
